// File: rtl/stack_queue_engine.sv
// Single-memory buffer whose ordering (FIFO or LIFO) is selected at run time while empty.
// Occupancy, almost-full and sticky overflow/underflow are decoded from registered state only.
module stack_queue_engine #(
   parameter int DinLENGTH = 32,
   parameter int DEPTH     = 16,
   parameter int AF_LEVEL  = DEPTH - 2,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode_req,
   input  logic                 push,
   input  logic [DinLENGTH-1:0] din,
   input  logic                 pop,
   input  logic                 flush,
   output logic [DinLENGTH-1:0] dout,
   output logic                 dout_valid,
   output logic                 mode,
   output logic [CW-1:0]        count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      MODE_FIFO = 1'b0,
      MODE_LIFO = 1'b1
   } mode_e;

   logic [DinLENGTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wp_q, wp_d;
   logic [AW-1:0]        rp_q, rp_d;
   logic [CW-1:0]        count_q, count_d;
   logic [DinLENGTH-1:0] dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   mode_e                mode_q, mode_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   logic                 is_empty, is_full;
   logic                 pop_acc, push_acc;
   logic [AW-1:0]        top_idx;
   logic                 mem_we;
   logic [AW-1:0]        mem_waddr;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));
   assign pop_acc  = pop && !is_empty;
   // A full buffer still takes a push when a pop frees a slot on the same edge.
   assign push_acc = push && (!is_full || pop_acc);
   assign top_idx  = AW'(count_q - CW'(1));

   always_comb begin
      wp_d         = wp_q;
      rp_d         = rp_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      mode_d       = mode_q;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      mem_we       = 1'b0;
      mem_waddr    = wp_q;

      if (flush) begin
         wp_d        = '0;
         rp_d        = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         // Re-home both pointers on an ordering change so the next FIFO use starts aligned.
         if (is_empty && !push) begin
            mode_d = mode_e'(mode_req);
            if (mode_e'(mode_req) != mode_q) begin
               wp_d = '0;
               rp_d = '0;
            end
         end

         dout_valid_d = pop_acc;
         if (pop && !pop_acc) underflow_d = 1'b1;
         if (push && !push_acc) overflow_d = 1'b1;

         if (mode_q == MODE_FIFO) begin
            if (push_acc) begin
               mem_we    = 1'b1;
               mem_waddr = wp_q;
               wp_d      = wp_q + AW'(1);
            end
            if (pop_acc) begin
               dout_d = mem_q[rp_q];
               rp_d   = rp_q + AW'(1);
            end
         end else begin
            if (pop_acc) dout_d = mem_q[top_idx];
            // Push alongside a pop overwrites the top just read (replace-top).
            if (push_acc) begin
               mem_we    = 1'b1;
               mem_waddr = pop_acc ? top_idx : count_q[AW-1:0];
            end
         end

         if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
         else if (pop_acc && !push_acc) count_d = count_q - CW'(1);

         if (mode_q == MODE_LIFO) wp_d = count_d[AW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q         <= '0;
         rp_q         <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         mode_q       <= MODE_FIFO;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         mode_q       <= mode_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage is never cleared; only the write is suppressed during reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem_q[mem_waddr] <= din;
   end

   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign mode        = mode_q;
   assign count       = count_q;
   assign full        = is_full;
   assign empty       = is_empty;
   assign almost_full = (count_q >= CW'(AF_LEVEL));
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_stack_queue_engine.sv
// Scoreboarded bench for stack_queue_engine: a queue-based reference model predicts
// status and popped data; a monitor checks every dout_valid pulse against exp_q.
module tb_stack_queue_engine;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int AF    = DEPTH - 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset, mode_req, push, pop, flush;
   logic [W-1:0]  din;
   logic [W-1:0]  dout;
   logic          dout_valid, mode, full, empty, almost_full, overflow, underflow;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   stack_queue_engine #(.DinLENGTH(W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
      .clk(clk), .reset(reset), .mode_req(mode_req), .push(push), .din(din),
      .pop(pop), .flush(flush), .dout(dout), .dout_valid(dout_valid), .mode(mode),
      .count(count), .full(full), .empty(empty), .almost_full(almost_full),
      .overflow(overflow), .underflow(underflow)
   );

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   // reference model state
   logic [W-1:0] m_q[$];
   logic         m_mode = 1'b0;
   logic         m_ovf  = 1'b0;
   logic         m_udf  = 1'b0;
   logic [W-1:0] m_dout = '0;
   logic         req_mode = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic p, input logic po, input logic [W-1:0] d,
                             input logic mr, input logic fl, input logic rs);
      int n;
      logic pop_ok, push_ok;
      logic [W-1:0] v;
      if (rs) begin
         m_q.delete(); m_mode = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
      end else if (fl) begin
         m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         n       = m_q.size();
         pop_ok  = po && (n > 0);
         push_ok = p && ((n < DEPTH) || pop_ok);
         if (pop_ok) begin
            if (m_mode) v = m_q.pop_back();
            else        v = m_q.pop_front();
            m_dout = v;
            exp_q.push_back(v);
         end
         if (po && !pop_ok) m_udf = 1'b1;
         if (p && !push_ok) m_ovf = 1'b1;
         if (push_ok) m_q.push_back(d);
         if (n == 0 && !p) m_mode = mr;
      end
   endtask

   task automatic check_status();
      int n;
      n = m_q.size();
      chk("count",       W'(count),       W'(n));
      chk("full",        W'(full),        W'(n == DEPTH));
      chk("empty",       W'(empty),       W'(n == 0));
      chk("almost_full", W'(almost_full), W'(n >= AF));
      chk("overflow",    W'(overflow),    W'(m_ovf));
      chk("underflow",   W'(underflow),   W'(m_udf));
      chk("mode",        W'(mode),        W'(m_mode));
      chk("dout_hold",   dout,            m_dout);
   endtask

   task automatic step(input logic p, input logic po, input logic [W-1:0] d,
                       input logic fl, input logic rs);
      push = p; pop = po; din = d; flush = fl; reset = rs; mode_req = req_mode;
      @(posedge clk);
      model_edge(p, po, d, req_mode, fl, rs);
      #1;
      check_status();
   endtask

   task automatic do_push(input logic [W-1:0] d); step(1'b1, 1'b0, d, 1'b0, 1'b0); endtask
   task automatic do_pop();                     step(1'b0, 1'b1, '0, 1'b0, 1'b0); endtask
   task automatic do_both(input logic [W-1:0] d); step(1'b1, 1'b1, d, 1'b0, 1'b0); endtask
   task automatic idle();                       step(1'b0, 1'b0, '0, 1'b0, 1'b0); endtask

   // monitor: every data pulse must match the oldest predicted pop
   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", W'(dout_valid), '0);
         end else begin
            chk("pop_data", dout, exp_q.pop_front());
         end
      end
   end

   initial begin
      push = 0; pop = 0; din = '0; flush = 0; reset = 1; mode_req = 0;
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("reset_valid", W'(dout_valid), '0);

      // FIFO order, then underflow, overflow, flush
      do_push(32'h11); do_push(32'h22); do_push(32'h33); do_push(32'h44);
      repeat (4) do_pop();
      do_pop();
      for (int i = 1; i <= 5; i++) do_push(W'(i));
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // FIFO simultaneous push+pop while full
      for (int i = 1; i <= 4; i++) do_push(W'(i));
      do_both(32'd5);
      repeat (4) do_pop();

      // LIFO order and replace-top
      req_mode = 1'b1;
      idle();
      do_push(32'h11); do_push(32'h22); do_push(32'h33); do_push(32'h44);
      do_push(32'h55);
      repeat (4) do_pop();
      do_push(32'd1); do_push(32'd2);
      do_both(32'd9);
      do_pop(); do_pop();
      do_both(32'd7);

      // FIFO pointer wrap with interleaved push/pop
      req_mode = 1'b0;
      idle();
      do_push(32'd100);
      for (int i = 1; i <= 10; i++) do_both(W'(100 + i));
      do_pop();

      // mode requests while non-empty stay pending
      do_push(32'hA1); do_push(32'hA2);
      req_mode = 1'b1; idle();
      req_mode = 1'b0; idle();
      req_mode = 1'b1; idle();
      do_pop(); do_pop();
      idle();
      idle();

      // reset mid-burst
      do_push(32'hB1); do_push(32'hB2); do_push(32'hB3);
      step(1'b1, 1'b1, 32'hB4, 1'b1, 1'b1);
      chk("reset_mid_valid", W'(dout_valid), '0);
      step(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic p, po, fl, rs;
         p  = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 50);
         fl = ($urandom_range(0, 39) == 0);
         rs = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 7) == 0) req_mode = ~req_mode;
         step(p, po, W'($urandom), fl, rs);
      end

      idle(); idle();
      chk("exp_q_drained", W'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
